memctrl_q_push: RTL

Enqueue (push-in) side of the memory-controller request queue. Accepts parsed trace requests over a valid/ready handshake and holds one in a staging register until simulation time reaches its arrival time. It then pushes the request into the queue, back-pressuring while the queue is full. The block owns the simulation time counter and the queue occupancy count; the pop-out logic drains the queue and reports each removal on `pop_i`.

---
 rtl/memctrl_pkg.sv | 43 ++++
 rtl/memctrl_occ_counter.sv | 60 ++++++
 rtl/memctrl_q_push.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/memctrl_pkg.sv
// -----------------------------------------------------------------------------
// memctrl_pkg
// Shared types and default widths for the memory-controller request queue.
//   TIME_W / ADDR_W / CORE_W : default field widths of a trace request
//   op_e                     : request operation encoding
//   req_t                    : packed trace request {req_time, core, op, addr}
//   stage_state_e            : states of the enqueue-side staging FSM
//   time_reached()           : unsigned "now has reached due" comparison
// -----------------------------------------------------------------------------
package memctrl_pkg;

  localparam int TIME_W = 64;
  localparam int ADDR_W = 36;
  localparam int CORE_W = 4;

  // Encoding 3 is reserved; it is carried through the queue untouched.
  typedef enum logic [1:0] {
    OP_READ   = 2'd0,
    OP_WRITE  = 2'd1,
    OP_IFETCH = 2'd2,
    OP_RSVD   = 2'd3
  } op_e;

  // The arrival-time field is called req_time because 'time' is a keyword.
  typedef struct packed {
    logic [TIME_W-1:0] req_time;
    logic [CORE_W-1:0] core;
    op_e               op;
    logic [ADDR_W-1:0] addr;
  } req_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_STALL = 2'd2
  } stage_state_e;

  function automatic logic time_reached(input logic [TIME_W-1:0] now,
                                        input logic [TIME_W-1:0] due);
    return now >= due;
  endfunction

endpackage

// File: rtl/memctrl_occ_counter.sv
// -----------------------------------------------------------------------------
// memctrl_occ_counter
// Up/down occupancy counter for the request queue.
//   clk, rst     : clock, asynchronous active-high reset
//   push         : one entry enters the queue at this edge
//   pop          : one entry leaves the queue at this edge
//   count        : registered occupancy, 0..QDEPTH
//   empty / full : count == 0 / count == QDEPTH
//   underflow    : sticky, set by a pop while empty, cleared only by reset
// -----------------------------------------------------------------------------
module memctrl_occ_counter
  import memctrl_pkg::*;
#(
  parameter int QDEPTH = 16,
  localparam int CNT_W = $clog2(QDEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full,
  output logic             underflow
);

  logic [CNT_W-1:0] count_q;
  logic             underflow_q;
  logic             do_push;
  logic             do_pop;

  // A pop on an empty queue is dropped so the count never wraps; a push
  // into a full queue is dropped for the same reason even though the
  // enqueue side never requests one.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Simultaneous push and pop cancel out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q     <= '0;
      underflow_q <= 1'b0;
    end else begin
      if (do_push && !do_pop) begin
        count_q <= count_q + CNT_W'(1);
      end else if (do_pop && !do_push) begin
        count_q <= count_q - CNT_W'(1);
      end
      if (pop && empty) begin
        underflow_q <= 1'b1;
      end
    end
  end

  assign count     = count_q;
  assign empty     = (count_q == '0);
  assign full      = (count_q == CNT_W'(QDEPTH));
  assign underflow = underflow_q;

endmodule

// File: rtl/memctrl_q_push.sv
// -----------------------------------------------------------------------------
// memctrl_q_push
// Enqueue side of the memory-controller request queue. A trace request is
// accepted over valid/ready, held in a staging register until simulation time
// reaches its arrival time, then pushed into the queue (stalling while full).
// This block owns the simulation time counter and the occupancy count.
//
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   req_valid_i   : trace request valid
//   req_ready_o   : staging register empty, request can be accepted
//   req_i         : trace request {req_time, core, op, addr}
//   pop_i         : pop-out logic removed one entry this cycle
//   push_valid_o  : push push_data_o into the queue at this edge
//   push_data_o   : staged request
//   sim_time_o    : current simulation time
//   count_o       : queue occupancy
//   empty_o       : count_o == 0
//   full_o        : count_o == QDEPTH
//   underflow_o   : sticky, pop_i seen while the queue was empty
//
// Build option: MEMCTRL_TIMESKIP_EN -- while the queue is empty and the staged
// request lies in the future, simulation time jumps straight to its arrival
// time instead of counting up one cycle at a time.
// -----------------------------------------------------------------------------
module memctrl_q_push #(
  parameter int QDEPTH = 16,
  parameter int TIME_W = memctrl_pkg::TIME_W,
  parameter int ADDR_W = memctrl_pkg::ADDR_W,
  parameter int CORE_W = memctrl_pkg::CORE_W,
  localparam int CNT_W = $clog2(QDEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  memctrl_pkg::req_t   req_i,
  input  logic                pop_i,
  output logic                push_valid_o,
  output memctrl_pkg::req_t   push_data_o,
  output logic [TIME_W-1:0]   sim_time_o,
  output logic [CNT_W-1:0]    count_o,
  output logic                empty_o,
  output logic                full_o,
  output logic                underflow_o
);

  import memctrl_pkg::*;

  stage_state_e      state_q;
  stage_state_e      state_d;
  logic              capture;
  logic              staged;
  logic              time_met;

  logic [TIME_W-1:0] sim_time_q;
  logic [TIME_W-1:0] sim_time_d;

  logic [TIME_W-1:0] stage_time;
  logic [CORE_W-1:0] stage_core;
  op_e               stage_op;
  logic [ADDR_W-1:0] stage_addr;

  logic              occ_empty;
  logic              occ_full;

  assign staged   = (state_q != ST_IDLE);
  assign time_met = time_reached(sim_time_q, stage_time);

  // Push eligibility is built only from registers, so a pop that frees a
  // slot in a full queue lets the staged request in on the following cycle.
  assign push_valid_o = staged && time_met && !occ_full;

  // Staging FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and handshake logic. STALL marks a request that is already
  // time-eligible but blocked by a full queue; once time is met it stays met,
  // so the request only moves between WAIT/STALL and back to IDLE on a push.
  always_comb begin
    state_d     = state_q;
    req_ready_o = 1'b0;
    capture     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          capture = 1'b1;
          if (time_reached(sim_time_q, req_i.req_time) && occ_full) begin
            state_d = ST_STALL;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT, ST_STALL: begin
        if (push_valid_o) begin
          state_d = ST_IDLE;
        end else if (time_met && occ_full) begin
          state_d = ST_STALL;
        end else begin
          state_d = ST_WAIT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Staging register. Reset clears it so a dropped request leaves no trace
  // on push_data_o.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_time <= '0;
      stage_core <= '0;
      stage_op   <= OP_READ;
      stage_addr <= '0;
    end else if (capture) begin
      stage_time <= req_i.req_time;
      stage_core <= req_i.core;
      stage_op   <= req_i.op;
      stage_addr <= req_i.addr;
    end
  end

  assign push_data_o = '{req_time: stage_time,
                         core:     stage_core,
                         op:       stage_op,
                         addr:     stage_addr};

  // Next simulation time. The skip only fires when nothing queued could
  // still need the intervening cycles, i.e. the queue is empty.
  always_comb begin
    sim_time_d = sim_time_q + TIME_W'(1);
`ifdef MEMCTRL_TIMESKIP_EN
    if (occ_empty && staged && (stage_time > sim_time_q)) begin
      sim_time_d = stage_time;
    end
`else
`endif
  end

  // Simulation time register; wraps naturally at 2^TIME_W.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sim_time_q <= '0;
    end else begin
      sim_time_q <= sim_time_d;
    end
  end

  assign sim_time_o = sim_time_q;

  memctrl_occ_counter #(
    .QDEPTH (QDEPTH)
  ) u_occ (
    .clk       (clk),
    .rst       (rst),
    .push      (push_valid_o),
    .pop       (pop_i),
    .count     (count_o),
    .empty     (occ_empty),
    .full      (occ_full),
    .underflow (underflow_o)
  );

  assign empty_o = occ_empty;
  assign full_o  = occ_full;

endmodule
